// File: rtl/snn_pkg.sv
// Types and defaults shared by the activation loader, input_value_mem and controller_SM_updated.
// sat_act clamps an unsigned value to the largest code that fits in act_w bits.
package snn_pkg;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    DONE      = 2'd1,
    WAIT_STEP = 2'd2
  } loader_state_t;

  localparam int unsigned ACT_W_DEF  = 8;
  localparam int unsigned ADDR_W_DEF = 10;

  function automatic logic [63:0] sat_act(input logic [63:0] in, input int unsigned act_w);
    logic [63:0] max_v;
    max_v = (64'd1 << act_w) - 64'd1;
    return (in > max_v) ? max_v : in;
  endfunction

endpackage

// File: rtl/step_frame_counter.sv
// Counts finished timesteps within a frame; step_idx_o advances one cycle after step_adv_i.
// frame_done_o pulses together with the wrap back to step 0; wrap_o is the same-cycle wrap strobe.
module step_frame_counter #(
  parameter int unsigned NUM_STEPS = 8,
  parameter int unsigned STEP_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_adv_i,
  output logic [STEP_W-1:0] step_idx_o,
  output logic              frame_done_o,
  output logic              wrap_o
);

  logic [STEP_W-1:0] step_q, step_d;
  logic              fd_q, fd_d;
  logic              last_step;

  assign last_step = (step_q == STEP_W'(NUM_STEPS - 1));
  assign wrap_o    = step_adv_i & last_step;

  always_comb begin
    step_d = step_q;
    fd_d   = 1'b0;
    if (step_adv_i) begin
      if (last_step) begin
        step_d = '0;
        fd_d   = 1'b1;
      end else begin
        step_d = step_q + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q <= '0;
      fd_q   <= 1'b0;
    end else begin
      step_q <= step_d;
      fd_q   <= fd_d;
    end
  end

  assign step_idx_o   = step_q;
  assign frame_done_o = fd_q;

endmodule

// File: rtl/activation_stream_loader.sv
// Streams saturated samples into input_value_mem, pulses pre_processing_done after the last write,
// then holds the stream off until the controller reports current_step_finished.
module activation_stream_loader
  import snn_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 1023,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned IN_W       = 16,
  parameter int unsigned ACT_W      = ACT_W_DEF,
  parameter int unsigned NUM_STEPS  = 8,
  localparam int unsigned STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] addr_in,
  output logic              act_wr_en,
  output logic [ACT_W-1:0]  data_in,
  output logic              pre_processing_done,
  input  logic              current_step_finished,
  output logic [STEP_W-1:0] step_idx,
  output logic              frame_done,
  output logic              sat_flag,
  output logic              proto_err
);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ACT_W-1:0]  data_q, data_d;
  logic              rdy_q, rdy_d;
  logic              wr_q, wr_d;
  logic              ppd_q, ppd_d;
  logic              sat_q, sat_d;
  logic              perr_q, perr_d;

  logic              accept;
  logic              last_beat;
  logic              step_adv;
  logic              wrap;
  logic              in_sat;
  logic [63:0]       sat_val;

  assign accept    = in_valid & rdy_q;
  assign sat_val   = sat_act(64'(in_data), ACT_W);
  assign in_sat    = (sat_val != 64'(in_data));
  assign last_beat = (idx_q == ADDR_W'(NUM_INPUTS - 1));

  // The state register already reads WAIT_STEP during the pre_processing_done cycle,
  // but a finish strobe there belongs to no loaded timestep, so it is excluded.
  assign step_adv  = current_step_finished & (state_q == WAIT_STEP) & ~ppd_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdy_d   = rdy_q;
    wr_d    = 1'b0;
    ppd_d   = 1'b0;
    sat_d   = sat_q;
    perr_d  = perr_q | (current_step_finished & ~step_adv);

    unique case (state_q)
      LOAD: begin
        rdy_d = 1'b1;
        if (accept) begin
          wr_d   = 1'b1;
          addr_d = idx_q;
          data_d = sat_val[ACT_W-1:0];
          idx_d  = idx_q + ADDR_W'(1);
          if (in_sat) begin
            sat_d = 1'b1;
          end
          if (last_beat) begin
            rdy_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        rdy_d   = 1'b0;
        ppd_d   = 1'b1;
        idx_d   = '0;
        state_d = WAIT_STEP;
      end
      WAIT_STEP: begin
        rdy_d = 1'b0;
        if (step_adv) begin
          rdy_d   = 1'b1;
          state_d = LOAD;
        end
      end
      default: begin
        rdy_d   = 1'b0;
        state_d = LOAD;
      end
    endcase

    if (wrap) begin
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      wr_q    <= 1'b0;
      ppd_q   <= 1'b0;
      sat_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      wr_q    <= wr_d;
      ppd_q   <= ppd_d;
      sat_q   <= sat_d;
      perr_q  <= perr_d;
    end
  end

  step_frame_counter #(
    .NUM_STEPS (NUM_STEPS),
    .STEP_W    (STEP_W)
  ) u_step_frame_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .step_adv_i   (step_adv),
    .step_idx_o   (step_idx),
    .frame_done_o (frame_done),
    .wrap_o       (wrap)
  );

  assign in_ready            = rdy_q;
  assign act_wr_en           = wr_q;
  assign addr_in             = addr_q;
  assign data_in             = data_q;
  assign pre_processing_done = ppd_q;
  assign sat_flag            = sat_q;
  assign proto_err           = perr_q;

endmodule

// File: tb/tb_activation_stream_loader.sv
// Scoreboard bench for activation_stream_loader with NUM_INPUTS=4, NUM_STEPS=2.
// The driver queues expected writes on acceptance; a negedge monitor pops and compares them.
module tb_activation_stream_loader;

  localparam int unsigned N = 4;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [9:0]  addr_in;
  logic        act_wr_en;
  logic [7:0]  data_in;
  logic        pre_processing_done;
  logic        current_step_finished;
  logic [0:0]  step_idx;
  logic        frame_done;
  logic        sat_flag;
  logic        proto_err;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   wr_cnt = 0;
  logic exp_ppd = 1'b0;
  logic [9:0] model_idx = '0;
  wr_t  exp_q[$];

  activation_stream_loader #(
    .NUM_INPUTS (N),
    .ADDR_W     (10),
    .IN_W       (16),
    .ACT_W      (8),
    .NUM_STEPS  (2)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .in_valid              (in_valid),
    .in_data               (in_data),
    .in_ready              (in_ready),
    .addr_in               (addr_in),
    .act_wr_en             (act_wr_en),
    .data_in               (data_in),
    .pre_processing_done   (pre_processing_done),
    .current_step_finished (current_step_finished),
    .step_idx              (step_idx),
    .frame_done            (frame_done),
    .sat_flag              (sat_flag),
    .proto_err             (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge where the resulting write is visible (+gap).
  task automatic send(input logic [15:0] d, input logic [7:0] ed, input int gap);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (in_ready !== 1'b1) begin
      chk("send_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back('{model_idx, ed});
      model_idx = (model_idx == 10'(N - 1)) ? 10'd0 : model_idx + 10'd1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic pulse_step();
    current_step_finished = 1'b1;
    @(negedge clk);
    current_step_finished = 1'b0;
  endtask

  // Monitor
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_ppd = 1'b0;
      end else begin
        if (exp_ppd) begin
          chk("ppd_after_last_wr", 64'(pre_processing_done), 64'd1);
          exp_ppd = 1'b0;
        end else if (pre_processing_done) begin
          chk("ppd_unexpected", 64'(pre_processing_done), 64'd0);
        end
        if (act_wr_en) begin
          wr_cnt++;
          if (exp_q.size() == 0) begin
            chk("wr_unexpected", 64'(act_wr_en), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(addr_in), 64'(e.addr));
            chk("wr_data", 64'(data_in), 64'(e.data));
            if (e.addr == 10'(N - 1)) exp_ppd = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int w0;
    int rdy_cycles;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    current_step_finished = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",   64'(in_ready), 64'd0);
    chk("rst_act_wr_en",  64'(act_wr_en), 64'd0);
    chk("rst_addr_in",    64'(addr_in), 64'd0);
    chk("rst_data_in",    64'(data_in), 64'd0);
    chk("rst_ppd",        64'(pre_processing_done), 64'd0);
    chk("rst_step_idx",   64'(step_idx), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_sat_flag",   64'(sat_flag), 64'd0);
    chk("rst_proto_err",  64'(proto_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 64'(in_ready), 64'd1);

    // Continuous stream 10,20,30,40
    c0 = cyc;
    send(16'd10, 8'd10, 0);
    send(16'd20, 8'd20, 0);
    send(16'd30, 8'd30, 0);
    send(16'd40, 8'd40, 0);
    chk("t1_consecutive", 64'(cyc - c0), 64'd4);
    @(negedge clk);
    @(negedge clk);
    chk("t1_rdy_low",   64'(in_ready), 64'd0);
    chk("t1_hold_addr", 64'(addr_in), 64'd3);
    chk("t1_hold_data", 64'(data_in), 64'd40);
    chk("t1_wr_off",    64'(act_wr_en), 64'd0);

    // Stall in WAIT_STEP with valid held high
    in_valid = 1'b1;
    in_data = 16'd99;
    rdy_cycles = 0;
    repeat (20) begin
      @(negedge clk);
      if (in_ready) rdy_cycles++;
    end
    chk("stall_rdy_cycles", 64'(rdy_cycles), 64'd0);
    pulse_step();
    chk("step1_rdy",  64'(in_ready), 64'd1);
    chk("step1_idx",  64'(step_idx), 64'd1);
    chk("step1_nofd", 64'(frame_done), 64'd0);
    send(16'd99, 8'd99, 0);

    // Saturation at index 1, protocol error at index 3
    send(16'd300, 8'd255, 0);
    chk("sat_set", 64'(sat_flag), 64'd1);
    send(16'd30, 8'd30, 0);
    pulse_step();
    chk("proto_in_load", 64'(proto_err), 64'd1);
    chk("proto_step_hold", 64'(step_idx), 64'd1);
    chk("proto_rdy_load", 64'(in_ready), 64'd1);
    send(16'd255, 8'd255, 0);
    chk("sat_still", 64'(sat_flag), 64'd1);
    @(negedge clk);
    @(negedge clk);
    pulse_step();
    chk("wrap_fd",   64'(frame_done), 64'd1);
    chk("wrap_step", 64'(step_idx), 64'd0);
    chk("wrap_sat",  64'(sat_flag), 64'd0);
    chk("wrap_rdy",  64'(in_ready), 64'd1);
    @(negedge clk);
    chk("fd_one_cycle", 64'(frame_done), 64'd0);
    chk("proto_sticky", 64'(proto_err), 64'd1);

    // Reset after 2 of 4 writes
    send(16'd1, 8'd1, 0);
    send(16'd2, 8'd2, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_in_ready",  64'(in_ready), 64'd0);
    chk("rst2_act_wr_en", 64'(act_wr_en), 64'd0);
    chk("rst2_addr_in",   64'(addr_in), 64'd0);
    chk("rst2_data_in",   64'(data_in), 64'd0);
    chk("rst2_proto",     64'(proto_err), 64'd0);
    chk("rst2_step",      64'(step_idx), 64'd0);
    exp_q.delete();
    model_idx = '0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_rdy_release", 64'(in_ready), 64'd1);

    // Valid toggling every other cycle, then a finish strobe on the pre_processing_done cycle
    w0 = wr_cnt;
    send(16'd5, 8'd5, 1);
    send(16'd6, 8'd6, 1);
    send(16'd7, 8'd7, 1);
    send(16'd8, 8'd8, 0);
    @(negedge clk);
    chk("toggle_ppd_now", 64'(pre_processing_done), 64'd1);
    pulse_step();
    chk("toggle_wr_count", 64'(wr_cnt - w0), 64'd4);
    chk("ppd_csf_proto",   64'(proto_err), 64'd1);
    chk("ppd_csf_rdy",     64'(in_ready), 64'd0);
    chk("ppd_csf_step",    64'(step_idx), 64'd0);
    pulse_step();
    chk("late_csf_rdy",  64'(in_ready), 64'd1);
    chk("late_csf_step", 64'(step_idx), 64'd1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
